// File: rtl/seven_segment_mux_controller.sv
// Multiplexed common-anode seven-segment driver with a tear-free double-buffered
// value load, per-digit blanking and decimal points, leading-zero suppression and PWM dimming.
module seven_segment_mux_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_PERIOD = 100000,
    parameter int BRIGHT_BITS  = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    val_valid_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress_in,
    input  logic [BRIGHT_BITS-1:0]  brightness_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out,
    output logic                    update_out
);
    localparam int CW = $clog2(COUNT_PERIOD + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = CW + BRIGHT_BITS + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_PERIOD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] SLOT_LEN = PW'(COUNT_PERIOD + 1);

    function automatic logic [6:0] font(input logic [3:0] nib);
        case (nib)
            4'h0:    font = 7'h3F;
            4'h1:    font = 7'h06;
            4'h2:    font = 7'h5B;
            4'h3:    font = 7'h4F;
            4'h4:    font = 7'h66;
            4'h5:    font = 7'h6D;
            4'h6:    font = 7'h7D;
            4'h7:    font = 7'h07;
            4'h8:    font = 7'h7F;
            4'h9:    font = 7'h6F;
            4'hA:    font = 7'h77;
            4'hB:    font = 7'h7C;
            4'hC:    font = 7'h39;
            4'hD:    font = 7'h5E;
            4'hE:    font = 7'h79;
            4'hF:    font = 7'h71;
            default: font = 7'h00;
        endcase
    endfunction

    // Bit k set when nibbles k..top are all zero; digit 0 is never flagged.
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic run;
        run = 1'b1;
        lead_zero_mask = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run = run & (v[4*k +: 4] == 4'h0);
            lead_zero_mask[k] = run;
        end
    endfunction

    logic [CW-1:0]           cnt_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] pend_val_r, disp_val_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r, disp_dp_r;
    logic                    pend_flag_r;
    logic [6:0]              cat_r;
    logic                    dp_r, frame_r, update_r;
    logic [NUM_DIGITS-1:0]   an_r;

    logic                    slot_end_s, boundary_s, hit_s, dark_s, dp_sel_s, pwm_on_s, en_s;
    logic [3:0]              nib_s;
    logic [NUM_DIGITS-1:0]   supp_mask_s, an_nxt_s;
    logic [PW-1:0]           pwm_lhs_s, pwm_rhs_s;

    assign slot_end_s = (cnt_r == CNT_LAST);
    assign boundary_s = slot_end_s && (idx_r == IDX_LAST);

    // Slot counter and scanned digit index
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= {IW{1'b0}};
        end else if (slot_end_s) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Pending/display double buffer; the display only changes at the frame boundary
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_val_r  <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r   <= {NUM_DIGITS{1'b0}};
            pend_flag_r <= 1'b0;
            disp_val_r  <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r   <= {NUM_DIGITS{1'b0}};
        end else if (boundary_s && val_valid_in) begin
            disp_val_r  <= val_in;
            disp_dp_r   <= dp_in;
            pend_flag_r <= 1'b0;
        end else if (boundary_s && pend_flag_r) begin
            disp_val_r  <= pend_val_r;
            disp_dp_r   <= pend_dp_r;
            pend_flag_r <= 1'b0;
        end else if (val_valid_in) begin
            pend_val_r  <= val_in;
            pend_dp_r   <= dp_in;
            pend_flag_r <= 1'b1;
        end
    end

    // Select current digit's nibble/dp, darkening and PWM; widths chosen so nothing truncates
    always_comb begin
        nib_s       = 4'h0;
        dp_sel_s    = 1'b0;
        dark_s      = 1'b0;
        hit_s       = 1'b0;
        supp_mask_s = lz_suppress_in ? lead_zero_mask(disp_val_r) : {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hit_s    = (idx_r == IW'(k));
            nib_s    = nib_s | ({4{hit_s}} & disp_val_r[4*k +: 4]);
            dp_sel_s = dp_sel_s | (hit_s & disp_dp_r[k]);
            dark_s   = dark_s | (hit_s & (blank_in[k] | supp_mask_s[k]));
        end
        pwm_lhs_s = PW'(cnt_r) << BRIGHT_BITS;
        pwm_rhs_s = (PW'(brightness_in) + PW'(1)) * SLOT_LEN;
        pwm_on_s  = (pwm_lhs_s < pwm_rhs_s);
        en_s      = ~dark_s & pwm_on_s;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_nxt_s[k] = ~(en_s && (idx_r == IW'(k)));
        end
    end

    // Registered pin drivers and event pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            an_r     <= {NUM_DIGITS{1'b1}};
            cat_r    <= 7'h7F;
            dp_r     <= 1'b1;
            frame_r  <= 1'b0;
            update_r <= 1'b0;
        end else begin
            an_r     <= an_nxt_s;
            cat_r    <= en_s ? ~font(nib_s) : 7'h7F;
            dp_r     <= en_s ? ~dp_sel_s : 1'b1;
            frame_r  <= boundary_s;
            update_r <= boundary_s & (val_valid_in | pend_flag_r);
        end
    end

    assign an_out     = an_r;
    assign cat_out    = cat_r;
    assign dp_out     = dp_r;
    assign frame_out  = frame_r;
    assign update_out = update_r;

endmodule

// File: tb/tb_seven_segment_mux_controller.sv
// Self-checking bench: a cycle model pushes expected pin values to a scoreboard queue,
// popped and compared on the falling edge, plus directed window counts for the scan features.
module tb_seven_segment_mux_controller;
    localparam int N     = 4;
    localparam int CP    = 7;
    localparam int BB    = 2;
    localparam int SLOT  = CP + 1;
    localparam int FRAME = N * SLOT;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic [15:0]   val_in = 16'h0000;
    logic [3:0]    dp_in = 4'h0;
    logic          val_valid_in = 1'b0;
    logic [3:0]    blank_in = 4'h0;
    logic          lz_suppress_in = 1'b0;
    logic [BB-1:0] brightness_in = 2'd3;
    logic [6:0]    cat_out;
    logic          dp_out;
    logic [3:0]    an_out;
    logic          frame_out;
    logic          update_out;

    seven_segment_mux_controller #(.NUM_DIGITS(N), .COUNT_PERIOD(CP), .BRIGHT_BITS(BB)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .val_in(val_in), .dp_in(dp_in),
        .val_valid_in(val_valid_in), .blank_in(blank_in), .lz_suppress_in(lz_suppress_in),
        .brightness_in(brightness_in), .cat_out(cat_out), .dp_out(dp_out), .an_out(an_out),
        .frame_out(frame_out), .update_out(update_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cat;
        logic       dp;
        logic       frame;
        logic       update;
    } exp_t;

    logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    exp_t        exp_q [$];
    int          compared = 0;
    int          mismatched = 0;
    int unsigned t = 0;
    logic [15:0] m_val = 16'h0000, m_pval = 16'h0000;
    logic [3:0]  m_dp = 4'h0, m_pdp = 4'h0;
    logic        m_pflag = 1'b0;
    int          an_low [N];
    int          dp_low_cnt, upd_cnt, frm_cnt;
    logic [3:0]  dp_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: expected pins for each rising edge, derived from cycle count since reset
    initial begin
        exp_t e;
        int slot, dig, hi;
        logic bnd, on;
        logic [3:0] nib;
        forever begin
            @(posedge clk_in or negedge rst_n_in);
            if (!rst_n_in) begin
                t = 0; m_val = 16'h0000; m_pval = 16'h0000; m_dp = 4'h0; m_pdp = 4'h0;
                m_pflag = 1'b0;
                exp_q.delete();
            end else begin
                slot = int'(t % SLOT);
                dig  = int'((t / SLOT) % N);
                bnd  = (slot == SLOT - 1) && (dig == N - 1);
                hi   = 0;
                for (int k = 0; k < N; k++) if (m_val[4*k +: 4] != 4'h0) hi = k;
                nib  = m_val[4*dig +: 4];
                on   = !blank_in[dig] && !(lz_suppress_in && dig > hi)
                       && (slot * (1 << BB) < (int'(brightness_in) + 1) * SLOT);
                e.an     = on ? ~(4'b0001 << dig) : 4'hF;
                e.cat    = on ? ~font_tab[nib] : 7'h7F;
                e.dp     = on ? ~m_dp[dig] : 1'b1;
                e.frame  = bnd;
                e.update = bnd && (val_valid_in || m_pflag);
                exp_q.push_back(e);
                if (bnd && val_valid_in) begin
                    m_val = val_in; m_dp = dp_in; m_pflag = 1'b0;
                end else if (bnd && m_pflag) begin
                    m_val = m_pval; m_dp = m_pdp; m_pflag = 1'b0;
                end else if (val_valid_in) begin
                    m_pval = val_in; m_pdp = dp_in; m_pflag = 1'b1;
                end
                t++;
            end
        end
    end

    // Scoreboard pop/compare and window statistics on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_an", 32'(an_out), 32'(e.an));
                chk("sb_cat", 32'(cat_out), 32'(e.cat));
                chk("sb_dp", 32'(dp_out), 32'(e.dp));
                chk("sb_frame", 32'(frame_out), 32'(e.frame));
                chk("sb_update", 32'(update_out), 32'(e.update));
            end
            if (rst_n_in) begin
                for (int k = 0; k < N; k++) if (!an_out[k]) an_low[k]++;
                if (!dp_out) begin
                    dp_low_cnt++;
                    dp_mask = dp_mask | ~an_out;
                end
                upd_cnt += int'(update_out);
                frm_cnt += int'(frame_out);
            end
        end
    end

    task automatic strobe(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk_in);
        val_in = v; dp_in = d; val_valid_in = 1'b1;
        @(negedge clk_in);
        val_valid_in = 1'b0;
    endtask

    task automatic window(input int n);
        @(posedge clk_in); #1;
        for (int k = 0; k < N; k++) an_low[k] = 0;
        dp_low_cnt = 0; upd_cnt = 0; frm_cnt = 0; dp_mask = 4'h0;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk_an_low(input string tag, input int e3, input int e2, input int e1, input int e0);
        int exp_v [N];
        exp_v = '{e0, e1, e2, e3};
        for (int k = 0; k < N; k++) chk($sformatf("%s_d%0d", tag, k), 32'(an_low[k]), 32'(exp_v[k]));
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < FRAME + 8 && int'(t % FRAME) != ph; i++) @(negedge clk_in);
        chk("phase_wait", t % FRAME, 32'(ph));
    endtask

    initial begin
        rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_an", 32'(an_out), 32'hF);
        chk("rst_cat", 32'(cat_out), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'h1);
        chk("rst_frame", 32'(frame_out), 32'h0);
        chk("rst_update", 32'(update_out), 32'h0);
        @(negedge clk_in); #2 rst_n_in = 1'b1;

        // Basic value load: 1234 shows from the next frame, each digit lit a full slot
        strobe(16'h1234, 4'h0);
        repeat (FRAME + 8) @(negedge clk_in);
        window(FRAME);
        chk_an_low("full", SLOT, SLOT, SLOT, SLOT);
        chk("full_frames", 32'(frm_cnt), 32'd1);

        // Two strobes mid-frame: last one wins, single update pulse
        wait_phase(10);
        strobe(16'hAAAA, 4'h0);
        repeat (3) @(negedge clk_in);
        strobe(16'h5555, 4'h0);
        window(40);
        chk("lastwins_updates", 32'(upd_cnt), 32'd1);
        chk("lastwins_frames", 32'(frm_cnt), 32'd1);

        // Strobe in the boundary cycle is displayed in the frame that starts right after it
        wait_phase(FRAME - 1);
        val_in = 16'hBEEF; dp_in = 4'h0; val_valid_in = 1'b1;
        @(negedge clk_in);
        val_valid_in = 1'b0;
        chk("bnd_update", 32'(update_out), 32'h1);
        chk("bnd_frame", 32'(frame_out), 32'h1);
        @(negedge clk_in);
        chk("bnd_an_d0", 32'(an_out), 32'hE);
        chk("bnd_cat_d0", 32'(cat_out), 32'(~7'h71 & 7'h7F));

        // Leading-zero suppression
        lz_suppress_in = 1'b1;
        strobe(16'h0070, 4'h0);
        repeat (FRAME + 8) @(negedge clk_in);
        window(FRAME);
        chk_an_low("lz70", 0, 0, SLOT, SLOT);
        strobe(16'h0000, 4'h0);
        repeat (FRAME + 8) @(negedge clk_in);
        window(FRAME);
        chk_an_low("lz00", 0, 0, 0, SLOT);
        lz_suppress_in = 1'b0;

        // PWM brightness
        brightness_in = 2'd1;
        window(FRAME);
        chk_an_low("pwm1", 4, 4, 4, 4);
        brightness_in = 2'd0;
        window(FRAME);
        chk_an_low("pwm0", 2, 2, 2, 2);
        brightness_in = 2'd3;
        window(FRAME);
        chk_an_low("pwm3", SLOT, SLOT, SLOT, SLOT);

        // Blank mask and per-digit decimal point
        blank_in = 4'b0100;
        strobe(16'h1234, 4'b0001);
        repeat (FRAME + 8) @(negedge clk_in);
        window(FRAME);
        chk_an_low("blank", SLOT, 0, SLOT, SLOT);
        chk("dp_mask", 32'(dp_mask), 32'h1);
        chk("dp_low_cycles", 32'(dp_low_cnt), 32'(SLOT));
        blank_in = 4'b0000;

        // Asynchronous reset in the middle of a slot
        strobe(16'h9876, 4'hF);
        repeat (FRAME + 12) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_an", 32'(an_out), 32'hF);
        chk("arst_cat", 32'(cat_out), 32'h7F);
        chk("arst_dp", 32'(dp_out), 32'h1);
        chk("arst_frame", 32'(frame_out), 32'h0);
        chk("arst_update", 32'(update_out), 32'h0);
        @(negedge clk_in); #2 rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("restart_an", 32'(an_out), 32'hE);
        chk("restart_cat", 32'(cat_out), 32'(~7'h3F & 7'h7F));
        chk("restart_dp", 32'(dp_out), 32'h1);
        repeat (FRAME + 4) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
